// File: rtl/qupls_regs_seq_if.sv
// Purpose : shared instruction type and the handshake bundle of the register-list sequencer.
// Latency : none; wires and modports only.
// Backpressure: in_valid/in_ready on the decode side, uop_valid/uop_ready on the issue side.
// Ports   : flush, in_* (instruction plus register list), uop_* (one micro-op per register).
//           slave = sequencer view, master = producer/consumer view.

package qupls_regs_seq_pkg;
    typedef logic [31:0] instruction_t;
endpackage

interface qupls_regs_seq_if
    import qupls_regs_seq_pkg::*;
#(
    parameter int MASKW = 32,
    parameter int STEP  = 8
);
    localparam int REGW = $clog2(MASKW);
    localparam int OFFW = REGW + $clog2(STEP);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic             in_regs;
    instruction_t     in_instr;
    logic [MASKW-1:0] in_mask;
    logic             in_store;

    logic             uop_valid;
    logic             uop_ready;
    instruction_t     uop_instr;
    logic             uop_pass;
    logic [REGW-1:0]  uop_reg;
    logic [OFFW-1:0]  uop_offset;
    logic             uop_store;
    logic             uop_null;
    logic             uop_last;

    modport slave (
        input  flush, in_valid, in_regs, in_instr, in_mask, in_store, uop_ready,
        output in_ready, uop_valid, uop_instr, uop_pass, uop_reg, uop_offset,
               uop_store, uop_null, uop_last
    );

    modport master (
        output flush, in_valid, in_regs, in_instr, in_mask, in_store, uop_ready,
        input  in_ready, uop_valid, uop_instr, uop_pass, uop_reg, uop_offset,
               uop_store, uop_null, uop_last
    );
endinterface

// File: rtl/qupls_regs_seq.sv
// Purpose : expands an OP_REGS register-list instruction into one load/store micro-op per set bit.
// Latency : 1 cycle from input transfer to first uop; one uop per cycle after that.
// Backpressure: uop fields held while uop_ready=0; in_ready only in IDLE with the output slot free.
// Ports   : clk, rst_n (synchronous, active-low), io (qupls_regs_seq_if.slave).
// Config  : QUPLS_REGS_SEQ_STORE_DESCEND_EN -> store lists walk highest register first.

module qupls_regs_seq
    import qupls_regs_seq_pkg::*;
#(
    parameter int MASKW = 32,
    parameter int STEP  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    qupls_regs_seq_if.slave    io
);
    localparam int REGW = $clog2(MASKW);
    localparam int OFFW = REGW + $clog2(STEP);

    typedef enum logic {IDLE, EXPAND} state_t;

    state_t           state_q, state_d;
    logic [MASKW-1:0] rem_q, rem_d;     // bits still to emit, excluding the current uop
    logic             desc_q, desc_d;   // walking the current list high-to-low
    logic             vld_q, vld_d;
    instruction_t     instr_q, instr_d;
    logic             pass_q, pass_d;
    logic [REGW-1:0]  reg_q, reg_d;
    logic [OFFW-1:0]  off_q, off_d;
    logic             store_q, store_d;
    logic             null_q, null_d;
    logic             last_q, last_d;

    function automatic logic [REGW-1:0] pick_lo(input logic [MASKW-1:0] m);
        pick_lo = '0;
        for (int i = MASKW - 1; i >= 0; i--)
            if (m[i]) pick_lo = REGW'(i);
    endfunction

    function automatic logic [REGW-1:0] pick_hi(input logic [MASKW-1:0] m);
        pick_hi = '0;
        for (int i = 0; i < MASKW; i++)
            if (m[i]) pick_hi = REGW'(i);
    endfunction

    function automatic logic [REGW:0] popcnt(input logic [MASKW-1:0] m);
        popcnt = '0;
        for (int i = 0; i < MASKW; i++)
            popcnt = popcnt + (REGW+1)'(m[i]);
    endfunction

    logic             desc_in;
    logic             in_ready_c;
    logic             in_xfer;
    logic             out_xfer;
    logic [REGW-1:0]  first_idx;
    logic [MASKW-1:0] first_rest;
    logic [OFFW-1:0]  first_off;
    logic [REGW-1:0]  next_idx;
    logic [MASKW-1:0] next_rest;

`ifdef QUPLS_REGS_SEQ_STORE_DESCEND_EN
    assign desc_in = io.in_store;
`else
    assign desc_in = 1'b0;
`endif

    assign in_ready_c = (state_q == IDLE) && (!vld_q || io.uop_ready) && !io.flush;
    assign in_xfer    = io.in_valid && in_ready_c;
    assign out_xfer   = vld_q && io.uop_ready;

    assign first_idx  = desc_in ? pick_hi(io.in_mask) : pick_lo(io.in_mask);
    assign first_rest = io.in_mask & ~(MASKW'(1) << first_idx);
    // Offsets are rank-based whatever the walk order, so a descending walk
    // starts at the highest rank and counts down.
    assign first_off  = desc_in ? OFFW'(popcnt(io.in_mask) - 1'b1) * OFFW'(STEP) : '0;

    assign next_idx   = desc_q ? pick_hi(rem_q) : pick_lo(rem_q);
    assign next_rest  = rem_q & ~(MASKW'(1) << next_idx);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        desc_d  = desc_q;
        vld_d   = vld_q;
        instr_d = instr_q;
        pass_d  = pass_q;
        reg_d   = reg_q;
        off_d   = off_q;
        store_d = store_q;
        null_d  = null_q;
        last_d  = last_q;

        if (io.flush) begin
            state_d = IDLE;
            rem_d   = '0;
            vld_d   = 1'b0;
        end else if (in_xfer) begin
            vld_d   = 1'b1;
            instr_d = io.in_instr;
            desc_d  = desc_in;
            state_d = IDLE;
            rem_d   = '0;
            reg_d   = '0;
            off_d   = '0;
            pass_d  = 1'b0;
            null_d  = 1'b0;
            last_d  = 1'b1;
            store_d = io.in_regs && io.in_store;
            if (!io.in_regs) begin
                pass_d = 1'b1;
            end else if (io.in_mask == '0) begin
                null_d = 1'b1;
            end else begin
                reg_d   = first_idx;
                off_d   = first_off;
                rem_d   = first_rest;
                last_d  = (first_rest == '0);
                state_d = (first_rest != '0) ? EXPAND : IDLE;
            end
        end else if (out_xfer) begin
            if (state_q == EXPAND) begin
                reg_d   = next_idx;
                off_d   = desc_q ? off_q - OFFW'(STEP) : off_q + OFFW'(STEP);
                rem_d   = next_rest;
                last_d  = (next_rest == '0);
                state_d = (next_rest != '0) ? EXPAND : IDLE;
            end else begin
                vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            desc_q  <= 1'b0;
            vld_q   <= 1'b0;
            instr_q <= '0;
            pass_q  <= 1'b0;
            reg_q   <= '0;
            off_q   <= '0;
            store_q <= 1'b0;
            null_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            desc_q  <= desc_d;
            vld_q   <= vld_d;
            instr_q <= instr_d;
            pass_q  <= pass_d;
            reg_q   <= reg_d;
            off_q   <= off_d;
            store_q <= store_d;
            null_q  <= null_d;
            last_q  <= last_d;
        end
    end

    assign io.in_ready   = in_ready_c;
    assign io.uop_valid  = vld_q;
    assign io.uop_instr  = instr_q;
    assign io.uop_pass   = pass_q;
    assign io.uop_reg    = reg_q;
    assign io.uop_offset = off_q;
    assign io.uop_store  = store_q;
    assign io.uop_null   = null_q;
    assign io.uop_last   = last_q;
endmodule

// File: tb/tb_qupls_regs_seq.sv
// Purpose : scoreboard bench for qupls_regs_seq; expected uops queued at input acceptance.
// Latency : checks first uop one cycle after acceptance and no bubble between instructions.
// Backpressure: uop_ready driven fixed-high, held-low or random; held uops compared every cycle.

module tb_qupls_regs_seq;
    localparam int MASKW = 32;
    localparam int STEP  = 8;

    typedef struct packed {
        logic [31:0] instr;
        logic        pass;
        logic [4:0]  rg;
        logic [7:0]  off;
        logic        store;
        logic        nul;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    qupls_regs_seq_if #(.MASKW(MASKW), .STEP(STEP)) bus ();

    qupls_regs_seq #(.MASKW(MASKW), .STEP(STEP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   vld_cycles = 0;
    int   rdy_mode = 0;    // 0: always ready, 1: random, 2: held low

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Independent model: rank of each set bit gives its offset; order optionally reversed.
    task automatic push_model(input logic regs, input logic [31:0] mask,
                              input logic store, input logic [31:0] instr);
        exp_t tmp[$];
        exp_t e;
        int   rank;
        bit   desc;
        desc = 1'b0;
`ifdef QUPLS_REGS_SEQ_STORE_DESCEND_EN
        desc = store;
`endif
        if (!regs) begin
            e = '{instr: instr, pass: 1'b1, rg: 5'd0, off: 8'd0, store: 1'b0, nul: 1'b0, last: 1'b1};
            sb.push_back(e);
        end else if (mask == 32'd0) begin
            e = '{instr: instr, pass: 1'b0, rg: 5'd0, off: 8'd0, store: store, nul: 1'b1, last: 1'b1};
            sb.push_back(e);
        end else begin
            rank = 0;
            for (int i = 0; i < MASKW; i++) begin
                if (mask[i]) begin
                    e = '{instr: instr, pass: 1'b0, rg: 5'(i), off: 8'(rank * STEP),
                          store: store, nul: 1'b0, last: 1'b0};
                    if (desc) tmp.push_front(e); else tmp.push_back(e);
                    rank++;
                end
            end
            tmp[tmp.size()-1].last = 1'b1;
            foreach (tmp[k]) sb.push_back(tmp[k]);
        end
    endtask

    // Monitor: sample mid-cycle; a stalled uop is compared against the same queue head each cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && !bus.flush && bus.uop_valid) begin
            vld_cycles++;
            if (sb.size() == 0) begin
                chk("unexpected_uop", 64'd1, 64'd0);
            end else begin
                e = sb[0];
                chk("uop_instr",  64'(bus.uop_instr),  64'(e.instr));
                chk("uop_pass",   64'(bus.uop_pass),   64'(e.pass));
                chk("uop_reg",    64'(bus.uop_reg),    64'(e.rg));
                chk("uop_offset", 64'(bus.uop_offset), 64'(e.off));
                chk("uop_store",  64'(bus.uop_store),  64'(e.store));
                chk("uop_null",   64'(bus.uop_null),   64'(e.nul));
                chk("uop_last",   64'(bus.uop_last),   64'(e.last));
                if (bus.uop_ready) void'(sb.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.uop_ready = 1'b1;
            1:       bus.uop_ready = ($urandom_range(0, 3) != 0);
            default: bus.uop_ready = 1'b0;
        endcase
    end

    task automatic send(input logic regs, input logic [31:0] mask,
                        input logic store, input logic [31:0] instr);
        int n;
        bit ok;
        bus.in_valid = 1'b1;
        bus.in_regs  = regs;
        bus.in_mask  = mask;
        bus.in_store = store;
        bus.in_instr = instr;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 300) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) chk("accept_timeout", 64'd1, 64'd0);
        else     push_model(regs, mask, store, instr);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.uop_valid) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 1000) chk("drain_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        int c0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_regs   = 1'b0;
        bus.in_mask   = '0;
        bus.in_store  = 1'b0;
        bus.in_instr  = '0;
        bus.uop_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid",  64'(bus.uop_valid),  64'd0);
        chk("rst_reg",    64'(bus.uop_reg),    64'd0);
        chk("rst_offset", 64'(bus.uop_offset), 64'd0);
        chk("rst_flags",  64'({bus.uop_pass, bus.uop_null, bus.uop_last, bus.uop_store}), 64'd0);
        chk("rst_instr",  64'(bus.uop_instr),  64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Non-REGS pass-through: uop next cycle, input ready again in that cycle
        send(1'b0, 32'h0, 1'b0, 32'h1234_5678);
        @(negedge clk);
        chk("pass_latency_valid", 64'(bus.uop_valid), 64'd1);
        chk("pass_in_ready",      64'(bus.in_ready),  64'd1);
        @(posedge clk); #1;
        drain();

        // Load list 0x92 with ready held high: three cycles
        c0 = vld_cycles;
        send(1'b1, 32'h0000_0092, 1'b0, 32'hA000_0001);
        drain();
        chk("cycles_0x92", 64'(vld_cycles - c0), 64'd3);

        // Same list, stall on the second uop
        send(1'b1, 32'h0000_0092, 1'b0, 32'hA000_0002);
        @(negedge clk);
        rdy_mode = 2;
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid", 64'(bus.uop_valid), 64'd1);
            chk("stall_reg",   64'(bus.uop_reg),   64'd4);
        end
        rdy_mode = 0;
        @(posedge clk); #1;
        drain();

        // Empty list
        c0 = vld_cycles;
        send(1'b1, 32'h0, 1'b0, 32'hB000_0000);
        drain();
        chk("cycles_null", 64'(vld_cycles - c0), 64'd1);

        // Back-to-back: no bubble between last uop and next instruction
        c0 = vld_cycles;
        send(1'b1, 32'h0000_0092, 1'b0, 32'hC000_0001);
        send(1'b0, 32'h0, 1'b0, 32'hC000_0002);
        drain();
        chk("cycles_b2b", 64'(vld_cycles - c0), 64'd4);

        // Store list (reversed when the descending option is built in)
        send(1'b1, 32'h0000_0092, 1'b1, 32'hD000_0001);
        drain();

        // Full mask: 32 uops, last offset 248
        c0 = vld_cycles;
        send(1'b1, 32'hFFFF_FFFF, 1'b0, 32'hE000_0001);
        drain();
        chk("cycles_full", 64'(vld_cycles - c0), 64'd32);
        rdy_mode = 1;
        send(1'b1, 32'hFFFF_FFFF, 1'b1, 32'hE000_0002);
        drain();
        @(negedge clk);
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // Flush during the second uop of mask 0xF
        send(1'b1, 32'h0000_000F, 1'b0, 32'hF000_0001);
        @(posedge clk); #1;
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("flush_valid",    64'(bus.uop_valid), 64'd0);
        chk("flush_idle_rdy", 64'(bus.in_ready),  64'd1);
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of a store list
        send(1'b1, 32'h0000_0092, 1'b1, 32'h5000_0001);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_valid",  64'(bus.uop_valid),  64'd0);
        chk("midrst_reg",    64'(bus.uop_reg),    64'd0);
        chk("midrst_offset", 64'(bus.uop_offset), 64'd0);
        chk("midrst_flags",  64'({bus.uop_pass, bus.uop_null, bus.uop_last, bus.uop_store}), 64'd0);
        chk("midrst_instr",  64'(bus.uop_instr),  64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_valid", 64'(bus.uop_valid), 64'd0);
        end
        @(posedge clk); #1;

        // Random traffic with random backpressure
        rdy_mode = 1;
        for (int t = 0; t < 24; t++) begin
            logic [31:0] m;
            m = $urandom() & $urandom();
            if (t % 6 == 0) m = 32'h0;
            send(($urandom_range(0, 4) != 0), m, 1'($urandom_range(0, 1)), $urandom());
        end
        drain();
        rdy_mode = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end
endmodule

// File: doc/qupls_regs_seq.md
QUPLS_REGS_SEQ -- requirements
Module: qupls_regs_seq

Interface
REQ-001 SHALL have parameter MASKW, 32, width of register-list mask / number of architectural regs.
REQ-002 SHALL have parameter STEP, 8, byte offset increment per transferred register.
REQ-003 SHALL have ports: clk input 1 clock; rst_n input 1 reset; clock single, reset synchronous and active-low.
REQ-004 SHALL have ports: flush input 1 abort; in_valid input 1; in_ready output 1; in_regs input 1 decoded OP_REGS flag; in_instr input instruction_t; in_mask input MASKW register list; in_store input 1 (1=store list, 0=load list).
REQ-005 SHALL have ports: uop_valid output 1; uop_ready input 1; uop_instr output instruction_t; uop_pass output 1 non-REGS pass-through; uop_reg output $clog2(MASKW) register number; uop_offset output $clog2(MASKW)+$clog2(STEP) byte offset; uop_store output 1; uop_null output 1 empty list; uop_last output 1 final uop of instruction.

Function
REQ-006 SHALL implement states IDLE and EXPAND; input transfer when in_valid && in_ready; output transfer when uop_valid && uop_ready.
REQ-007 in_ready SHALL = (state==IDLE) && (!uop_valid || uop_ready), combinational.
REQ-008 Outputs SHALL be registered; first uop valid the cycle after input transfer (latency 1).
REQ-009 Non-REGS input (in_regs=0): one uop, uop_pass=1, uop_last=1, uop_instr=in_instr, uop_reg/offset=0; state stays IDLE.
REQ-010 REGS input, mask nonzero: one uop per set bit, lowest register first; uop_reg=bit index; uop_offset=STEP*(count of set bits below that index); uop_store=in_store; uop_instr=in_instr on every uop.
REQ-011 Remaining-mask register SHALL clear the emitted bit on each output transfer; state EXPAND while bits remain beyond current uop, IDLE when current uop is last.
REQ-012 uop_last=1 exactly on the uop for the final set bit; single-bit mask: first uop is last, no EXPAND entry.
REQ-013 REGS input, mask zero: single uop with uop_null=1, uop_last=1, uop_reg=0, uop_offset=0.
REQ-014 uop_valid held and all uop fields stable while uop_ready=0 (no drop, no change).
REQ-015 Back-to-back: input accepted in cycle of last-uop transfer; next instruction's first uop valid next cycle, no bubble.
REQ-016 Full mask (all MASKW bits): exactly MASKW uops, final offset STEP*(MASKW-1), no wrap.
REQ-017 flush SHALL, at the next edge, clear uop_valid, remaining mask, return to IDLE; flush has priority over simultaneous input/output transfer; in_ready=0 during flush cycle.

Reset
REQ-018 On clk edge with rst_n=0: state=IDLE, uop_valid=0, remaining mask=0, uop_pass/null/last/store=0, uop_reg=0, uop_offset=0, uop_instr=0.
REQ-019 Reset mid-expansion SHALL abandon remaining uops; no uop emitted after reset deasserts until new input transfer.

Configuration
REQ-020 Macro QUPLS_REGS_SEQ_STORE_DESCEND_EN: defined -> store lists (in_store=1) emit highest register first; undefined -> all lists lowest first.
REQ-021 With macro defined, uop_offset per register SHALL be unchanged (rank-based per REQ-010); only order and uop_last position change; loads unaffected.

Verification
REQ-022 Non-REGS instr, uop_ready=1 -> one uop next cycle, pass=1, last=1; in_ready high again same cycle.
REQ-023 REGS load mask=0x0000_0092, STEP=8 -> uops (reg1,off0),(reg4,off8),(reg7,off16,last); 3 cycles with uop_ready=1.
REQ-024 Same mask, uop_ready low cycles 2-4 -> reg4 uop held stable, no loss, sequence intact.
REQ-025 REGS mask=0 -> single uop null=1 last=1; mask=0xFFFF_FFFF -> 32 uops, final off=248, last only on reg31.
REQ-026 flush asserted during uop 2 of mask=0xF -> uop_valid=0 next cycle, state IDLE, in_ready=1.
REQ-027 Macro defined, store mask=0x0000_0092 -> (reg7,off16),(reg4,off8),(reg1,off0,last); rst_n=0 mid-list -> all outputs reset values.
